// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the swap FSM state type.
package vga_pkg;

    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 525;
    localparam int unsigned H_OFS   = 144;
    localparam int unsigned V_OFS   = 35;

    typedef enum logic {
        StIdle,
        StPend
    } swap_state_e;

endpackage

// File: rtl/dp_ram_param.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module dp_ram_param #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_framebuf_db.sv
// Double-buffered VGA framebuffer: writer fills the back buffer, display scans the front one,
// and a requested swap is deferred to the next frame end.
module vga_framebuf_db #(
    parameter int unsigned RGB_W   = 3,
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 32,
    parameter int unsigned H_OFS   = vga_pkg::H_OFS,
    parameter int unsigned V_OFS   = vga_pkg::V_OFS,
    parameter int unsigned IMG_X0  = 0,
    parameter int unsigned IMG_Y0  = 0,
    parameter int unsigned H_TOTAL = vga_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL = vga_pkg::V_TOTAL,
    parameter int unsigned BG      = 0,
    localparam int unsigned XW     = $clog2(IMG_W),
    localparam int unsigned YW     = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      c1,
    input  logic [10:0]      c2,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [XW-1:0]    wr_x,
    input  logic [YW-1:0]    wr_y,
    input  logic [RGB_W-1:0] wr_data,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             front_sel,
    output logic [RGB_W-1:0] rgb
);

    import vga_pkg::*;

    localparam int unsigned HStart = H_OFS + IMG_X0;
    localparam int unsigned VStart = V_OFS + IMG_Y0;
    localparam int unsigned AW     = 1 + YW + XW;
    localparam int unsigned Depth  = 2 * IMG_W * IMG_H;
    localparam logic [RGB_W-1:0] BgCol = RGB_W'(BG);

    swap_state_e      state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             win_q;
    logic [RGB_W-1:0] rgb_q;

    logic [10:0]      col_rel, row_rel;
    logic             in_x, in_y, in_win;
    logic             frame_end;
    logic             wr_en;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [RGB_W-1:0] ram_rdata;

    // Upper bits of the relative position must be zero; the lower-bound test stops wrap-around.
    assign col_rel = c1 - 11'(HStart);
    assign row_rel = c2 - 11'(VStart);
    assign in_x    = (c1 >= 11'(HStart)) && (col_rel[10:XW] == '0);
    assign in_y    = (c2 >= 11'(VStart)) && (row_rel[10:YW] == '0);
    assign in_win  = in_x && in_y;

    assign frame_end = (c1 == 11'(H_TOTAL - 1)) && (c2 == 11'(V_TOTAL - 1));

    assign wr_en   = wr_valid && wr_ready;
    assign wr_addr = {~front_sel_q, wr_y, wr_x};
    assign rd_addr = {front_sel_q, row_rel[YW-1:0], col_rel[XW-1:0]};

    dp_ram_param #(
        .WIDTH (RGB_W),
        .DEPTH (Depth)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        wr_ready    = 1'b0;
        swap_ack    = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_ready = 1'b1;
                if (swap_req) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (frame_end) begin
                    state_d     = StIdle;
                    front_sel_d = ~front_sel_q;
                    swap_ack    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            win_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            win_q       <= in_win;
            rgb_q       <= win_q ? ram_rdata : BgCol;
        end
    end

    assign front_sel = front_sel_q;
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_framebuf_db.sv
// Self-checking bench for vga_framebuf_db: directed sequences, a vector table and random traffic.
module tb_vga_framebuf_db;

    localparam logic [2:0] BgC = 3'd2;

    logic        clk;
    logic        rst;
    logic [10:0] c1, c2;
    logic        wr_valid, wr_ready;
    logic [5:0]  wr_x;
    logic [4:0]  wr_y;
    logic [2:0]  wr_data;
    logic        swap_req, swap_ack, front_sel;
    logic [2:0]  rgb;

    vga_framebuf_db #(
        .BG (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .c1        (c1),
        .c2        (c2),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .front_sel (front_sel),
        .rgb       (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int dut_acks = 0;

    // Reference model: two whole images plus the swap bookkeeping.
    logic [2:0] m_mem [4096];
    bit         m_known [4096];
    bit         m_front;
    bit         m_pend;
    bit         h1_ok, h2_ok;
    logic [2:0] h1_v, h2_v;

    typedef struct {
        int         x1;
        int         y1;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_pixel(input int x1, input int y1, output logic [2:0] v,
                                      output bit ok);
        int cx, cy, idx;
        cx = x1 - 144;
        cy = y1 - 35;
        if (cx >= 0 && cx < 64 && cy >= 0 && cy < 32) begin
            idx = int'(m_front) * 2048 + cy * 64 + cx;
            v   = m_mem[idx];
            ok  = m_known[idx];
        end else begin
            v  = BgC;
            ok = 1'b1;
        end
    endfunction

    task automatic cyc(input int x1, input int y1, input bit wv, input int wx, input int wy,
                       input logic [2:0] wd, input bit sr);
        bit         fe;
        bit         pok;
        logic [2:0] pv;
        int         widx;
        c1       = 11'(x1);
        c2       = 11'(y1);
        wr_valid = wv;
        wr_x     = 6'(wx);
        wr_y     = 5'(wy);
        wr_data  = wd;
        swap_req = sr;
        #1;
        fe = (x1 == 799) && (y1 == 524);
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
        chk("swap_ack", 32'(swap_ack), 32'(m_pend && fe));
        chk("front_sel", 32'(front_sel), 32'(m_front));
        if (h2_ok) chk("rgb", 32'(rgb), 32'(h2_v));
        if (swap_ack === 1'b1) dut_acks++;
        ref_pixel(x1, y1, pv, pok);
        h2_ok = h1_ok;
        h2_v  = h1_v;
        h1_ok = pok;
        h1_v  = pv;
        if (wv && !m_pend) begin
            widx          = (1 - int'(m_front)) * 2048 + wy * 64 + wx;
            m_mem[widx]   = wd;
            m_known[widx] = 1'b1;
        end
        if (!m_pend) begin
            if (sr) m_pend = 1'b1;
        end else if (fe) begin
            m_pend  = 1'b0;
            m_front = ~m_front;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_front = 1'b0;
        m_pend  = 1'b0;
        h1_ok   = 1'b0;
        h2_ok   = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x1, y1;
        rst = 1'b1;
        c1 = '0; c2 = '0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; swap_req = 1'b0;
        for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
        model_reset();

        tbl[0] = '{149, 38, 3'b101};
        tbl[1] = '{144, 35, 3'b011};
        tbl[2] = '{151, 42, 3'b110};
        tbl[3] = '{153, 44, 3'b001};
        tbl[4] = '{143, 38, BgC};
        tbl[5] = '{208, 38, BgC};
        tbl[6] = '{149, 34, BgC};
        tbl[7] = '{149, 67, BgC};

        // Reset state
        c1 = 11'd799; c2 = 11'd524;
        #2;
        chk("rst_front", 32'(front_sel), 32'd0);
        chk("rst_ack", 32'(swap_ack), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(wr_ready), 32'd1);

        // Fill back buffer 1 while buffer 0 is displayed
        cyc(0, 0, 1, 5, 3, 3'b101, 0);
        cyc(0, 0, 1, 0, 0, 3'b011, 0);
        cyc(0, 0, 1, 9, 9, 3'b001, 0);

        // Swap request with a same-cycle write, a refused write and a duplicate request in PEND
        dut_acks = 0;
        cyc(10, 100, 1, 7, 7, 3'b110, 1);
        cyc(11, 100, 1, 9, 9, 3'b111, 0);
        cyc(20, 100, 0, 0, 0, 3'b000, 1);
        for (int i = 0; i < 5; i++) cyc(100 + i, 200, 1, 9, 9, 3'b111, 0);
        cyc(799, 524, 0, 0, 0, 3'b000, 0);
        cyc(0, 0, 0, 0, 0, 3'b000, 0);
        chk("ack_after_swap", 32'(front_sel), 32'd1);
        cyc(799, 524, 0, 0, 0, 3'b000, 0);
        chk("ack_count", 32'(dut_acks), 32'd1);

        // Window edges and buffer-1 contents
        foreach (tbl[i]) begin
            repeat (3) cyc(tbl[i].x1, tbl[i].y1, 0, 0, 0, 3'b000, 0);
            chk("tbl_rgb", 32'(rgb), 32'(tbl[i].exp));
        end

        // Request on a frame-end cycle waits for the following frame end
        dut_acks = 0;
        cyc(799, 524, 0, 0, 0, 3'b000, 1);
        cyc(10, 10, 0, 0, 0, 3'b000, 0);
        cyc(799, 524, 0, 0, 0, 3'b000, 0);
        chk("fe_req_acks", 32'(dut_acks), 32'd1);
        chk("fe_req_front", 32'(front_sel), 32'd0);

        // Reset in PEND abandons the swap
        cyc(10, 100, 0, 0, 0, 3'b000, 1);
        c1 = 11'd799; c2 = 11'd524;
        rst = 1'b1;
        #1;
        chk("pend_rst_front", 32'(front_sel), 32'd0);
        chk("pend_rst_ack", 32'(swap_ack), 32'd0);
        chk("pend_rst_rgb", 32'(rgb), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("pend_rst_ready", 32'(wr_ready), 32'd1);
        cyc(799, 524, 0, 0, 0, 3'b000, 0);
        cyc(10, 100, 0, 0, 0, 3'b000, 1);
        cyc(799, 524, 0, 0, 0, 3'b000, 0);
        repeat (3) cyc(149, 38, 0, 0, 0, 3'b000, 0);
        chk("ram_kept", 32'(rgb), 32'(3'b101));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                x1 = 799;
                y1 = 524;
            end else begin
                x1 = int'($urandom_range(138, 182));
                y1 = int'($urandom_range(31, 54));
            end
            cyc(x1, y1, bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 15)), 3'($urandom), $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_framebuf_db.md
VGA_FRAMEBUF_DB -- requirements
Module: vga_framebuf_db

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RGB_W, 3, colour bits per pixel
- IMG_W, 64, image width in pixels (power of two)
- IMG_H, 32, image height in lines (power of two)
- H_OFS, 144, c1 value of the first active column (sync + back porch)
- V_OFS, 35, c2 value of the first active line
- IMG_X0, 0, image left edge, in active columns
- IMG_Y0, 0, image top edge, in active lines
- H_TOTAL, 800, columns per line
- V_TOTAL, 525, lines per frame
- BG, 0, colour driven outside the image window
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk in 1 system clock, the single clock
- rst in 1 reset, asynchronous, active-high
- c1 in 11 column counter from the sync generator, 0..H_TOTAL-1
- c2 in 11 line counter from the sync generator, 0..V_TOTAL-1
- wr_valid in 1 writer presents a pixel
- wr_ready out 1 block accepts a pixel
- wr_x in clog2(IMG_W) pixel column
- wr_y in clog2(IMG_H) pixel row
- wr_data in RGB_W pixel colour
- swap_req in 1 single-cycle request to exchange the front and back buffers
- swap_ack out 1 single-cycle pulse when the swap takes effect
- front_sel out 1 index of the buffer currently displayed
- rgb out RGB_W pixel colour to the DAC

Function
REQ-003 Storage SHALL be a 2*IMG_W*IMG_H-word by RGB_W dual-port RAM; address = {buffer, y, x}.
REQ-004 A write SHALL occur on each cycle with wr_valid=1 and wr_ready=1, at {~front_sel, wr_y, wr_x}.
REQ-005 The display address SHALL be {front_sel, c2-V_OFS-IMG_Y0, c1-H_OFS-IMG_X0}, truncated to the index widths.
REQ-006 The window flag SHALL be 1 iff c1-H_OFS-IMG_X0 is in 0..IMG_W-1 and c2-V_OFS-IMG_Y0 is in 0..IMG_H-1, computed without wrap-around (c1<H_OFS+IMG_X0 is outside).
REQ-007 RAM read latency SHALL be 1 cycle; the window flag SHALL be delayed to match; rgb SHALL be registered.
REQ-008 rgb SHALL equal the RAM word when the window flag is set, otherwise BG, exactly 2 cycles after the c1/c2 sample.
REQ-009 The swap FSM SHALL have states IDLE and PEND; wr_ready=1 only in IDLE.
REQ-010 IDLE->PEND on swap_req=1; a write presented in the same cycle SHALL be accepted.
REQ-011 PEND->IDLE on frame end (c1==H_TOTAL-1 and c2==V_TOTAL-1): front_sel toggles and swap_ack pulses for one cycle.
REQ-012 swap_req in PEND SHALL be ignored; no request is queued.
REQ-013 swap_req in IDLE on a frame-end cycle SHALL enter PEND and swap only at the next frame end.
REQ-014 Simultaneous write and read of the same RAM word SHALL NOT occur, because writes target only the back buffer.

Reset
REQ-015 Asserting rst SHALL immediately force state=IDLE, front_sel=0, swap_ack=0 and rgb=0; wr_ready SHALL be 1 after rst is released.
REQ-016 Reset mid-PEND SHALL abandon the swap with no swap_ack; RAM contents are not cleared.

Structure
REQ-017 A shared package vga_pkg SHALL hold H_TOTAL, V_TOTAL, H_OFS, V_OFS and the FSM state enumeration.
REQ-018 The RAM SHALL be a sub-module, dp_ram_param (parameters: width and depth), with one write port and one registered read port.

Verification
REQ-019 Write wr_x=5, wr_y=3, data 3'b101 in IDLE, front_sel=0. Then swap and drive c1=144+5, c2=35+3 -> rgb=3'b101 two cycles later.
REQ-020 Drive c1=143 or c1=144+64 within active lines -> rgb=BG; drive c1=144, c2=35 with buffer 1 word 0 = 3'b011 displayed -> 3'b011.
REQ-021 Pulse swap_req at c1=10, c2=100 -> wr_ready=0 until frame end. At c1=799, c2=524, swap_ack=1 for one cycle and front_sel toggles; wr_ready=1 on the next cycle.
REQ-022 Drive wr_valid with swap_req in the same cycle -> that write lands in the old back buffer. Pulse a second swap_req while PEND -> exactly one swap_ack.
REQ-023 Assert rst during PEND -> front_sel=0, no swap_ack, wr_ready=1 after release; previously written RAM words are still readable after a swap.
